axis_pkt_arbiter: RTL and testbench

Two-input, packet-granular round-robin arbiter placed in front of the cascaded AXI-Stream FIFO's write port. It lets two upstream producers share one FIFO. The grant is held for a whole packet, from first beat to the `Last` handshake, so packets are never interleaved. It enforces a maximum packet length by truncation and keeps per-source completed-packet counters for status.

---
 rtl/axis_pkt_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// Two-source, packet-granular round-robin arbiter feeding a FIFO write port.
// The grant is held from the first beat to the Last handshake, so packets are
// never interleaved. Packets longer than MaxBeats are cut with a forced Last,
// and completed packets are counted per source.
module axis_pkt_arbiter #(
  parameter int DataWidth  = 32,
  parameter int MaxBeats   = 2048,
  parameter int CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DataWidth-1:0]  in0Data,
  input  logic                  in0Valid,
  output logic                  in0Ready,
  input  logic                  in0Last,
  input  logic [DataWidth-1:0]  in1Data,
  input  logic                  in1Valid,
  output logic                  in1Ready,
  input  logic                  in1Last,
  output logic [DataWidth-1:0]  writeData,
  output logic                  writeDataValid,
  input  logic                  writeDataReady,
  output logic                  writeDataLast,
  output logic [1:0]            grant,
  output logic [1:0]            truncate,
  output logic [CountWidth-1:0] pktCount0,
  output logic [CountWidth-1:0] pktCount1
);

  localparam int BeatWidth = $clog2(MaxBeats + 1);
  localparam logic [BeatWidth-1:0] BeatLimit = BeatWidth'(MaxBeats - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic [BeatWidth-1:0] beat_q, beat_d;
  logic [1:0]           truncate_q, truncate_d;

  logic [DataWidth-1:0] src_data [2];
  logic [1:0]           src_valid;
  logic [1:0]           src_last;
  logic [1:0]           src_ready;
  logic [1:0]           src_end;
  logic                 owner;
  logic                 active;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 force_last;
  logic                 handshake;
  logic                 pkt_end;

  assign src_data[0] = in0Data;
  assign src_data[1] = in1Data;
  assign src_valid   = {in1Valid, in0Valid};
  assign src_last    = {in1Last, in0Last};

  assign active     = (state_q != IDLE);
  assign owner      = (state_q == GRANT1);
  assign sel_valid  = src_valid[owner];
  assign sel_last   = src_last[owner];
  // The beat that would become number MaxBeats must close the packet.
  assign force_last = active & (beat_q == BeatLimit) & ~sel_last;

  // Combinational pass-through of the granted source; everything 0 when idle.
  always_comb begin
    writeData      = '0;
    writeDataValid = 1'b0;
    writeDataLast  = 1'b0;
    if (active) begin
      writeData      = src_data[owner];
      writeDataValid = sel_valid;
      writeDataLast  = sel_last | force_last;
    end
  end

  assign handshake  = writeDataValid & writeDataReady;
  assign pkt_end    = handshake & writeDataLast;
  assign truncate_d = src_end & {2{force_last}};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_src
      localparam logic Idx = 1'(gi);
      logic [CountWidth-1:0] count_q;

      assign src_ready[gi] = active & (owner == Idx) & writeDataReady;
      assign src_end[gi]   = pkt_end & (owner == Idx);

      // Completed-packet counter for this source, wraps naturally.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_q <= '0;
        end else if (src_end[gi]) begin
          count_q <= count_q + CountWidth'(1);
        end
      end
    end
  endgenerate

  assign in0Ready  = src_ready[0];
  assign in1Ready  = src_ready[1];
  assign pktCount0 = gen_src[0].count_q;
  assign pktCount1 = gen_src[1].count_q;
  assign grant     = {state_q == GRANT1, state_q == GRANT0};
  assign truncate  = truncate_q;

  // Arbitration, beat counting and round-robin bookkeeping.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: begin
        if (in0Valid && in1Valid) begin
          state_d = last_owner_q ? GRANT0 : GRANT1;
        end else if (in0Valid) begin
          state_d = GRANT0;
        end else if (in1Valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (handshake) begin
          beat_d = beat_q + BeatWidth'(1);
        end
        if (pkt_end) begin
          beat_d       = '0;
          last_owner_d = owner;
          // Hand over at once if the other side waits. A truncated packet
          // still has beats pending, so its owner keeps going with no bubble;
          // after a genuine Last the arbiter returns to IDLE.
          if (src_valid[~owner]) begin
            state_d = owner ? GRANT0 : GRANT1;
          end else if (force_last && sel_valid) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner history, beat counter and truncate pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_q       <= '0;
      truncate_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
      truncate_q   <= truncate_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed, table-driven bench for axis_pkt_arbiter (MaxBeats=8, CountWidth=2).
module tb_axis_pkt_arbiter;

  localparam int DW = 8;
  localparam int MB = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in0Data, in1Data;
  logic          in0Valid, in0Ready, in0Last;
  logic          in1Valid, in1Ready, in1Last;
  logic [DW-1:0] writeData;
  logic          writeDataValid, writeDataReady, writeDataLast;
  logic [1:0]    grant, truncate;
  logic [CW-1:0] pktCount0, pktCount1;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.DataWidth(DW), .MaxBeats(MB), .CountWidth(CW)) dut (
    .clk(clk), .reset(reset),
    .in0Data(in0Data), .in0Valid(in0Valid), .in0Ready(in0Ready), .in0Last(in0Last),
    .in1Data(in1Data), .in1Valid(in1Valid), .in1Ready(in1Ready), .in1Last(in1Last),
    .writeData(writeData), .writeDataValid(writeDataValid),
    .writeDataReady(writeDataReady), .writeDataLast(writeDataLast),
    .grant(grant), .truncate(truncate), .pktCount0(pktCount0), .pktCount1(pktCount1)
  );

  typedef struct {
    logic          rst_n;
    logic          v0, l0;
    logic [DW-1:0] d0;
    logic          v1, l1;
    logic [DW-1:0] d1;
    logic          rdy;
    logic [1:0]    g;
    logic          r0, r1, wv, wl;
    logic [DW-1:0] wd;
    logic [1:0]    tr;
    logic [CW-1:0] c0, c1;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h required %0h", name, idx, act, exp);
    end
  endtask

  // Inputs: rst_n v0 l0 d0 v1 l1 d1 rdy | expected: grant r0 r1 wv wl wd trunc cnt0 cnt1
  task automatic add(input int rst_n, input int v0, input int l0, input int d0,
                     input int v1, input int l1, input int d1, input int rdy,
                     input int g, input int r0, input int r1, input int wv, input int wl,
                     input int wd, input int tr, input int c0, input int c1);
    vec_t v;
    v.rst_n = rst_n[0]; v.v0 = v0[0]; v.l0 = l0[0]; v.d0 = d0[DW-1:0];
    v.v1 = v1[0]; v.l1 = l1[0]; v.d1 = d1[DW-1:0]; v.rdy = rdy[0];
    v.g = g[1:0]; v.r0 = r0[0]; v.r1 = r1[0]; v.wv = wv[0]; v.wl = wl[0];
    v.wd = wd[DW-1:0]; v.tr = tr[1:0]; v.c0 = c0[CW-1:0]; v.c1 = c1[CW-1:0];
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst_n;
    in0Valid = v.v0; in0Last = v.l0; in0Data = v.d0;
    in1Valid = v.v1; in1Last = v.l1; in1Data = v.d1;
    writeDataReady = v.rdy;
  endtask

  task automatic check_outputs(input vec_t v, input int idx);
    chk("grant", idx, 32'(grant), 32'(v.g));
    chk("in0Ready", idx, 32'(in0Ready), 32'(v.r0));
    chk("in1Ready", idx, 32'(in1Ready), 32'(v.r1));
    chk("writeDataValid", idx, 32'(writeDataValid), 32'(v.wv));
    chk("writeDataLast", idx, 32'(writeDataLast), 32'(v.wl));
    chk("writeData", idx, 32'(writeData), 32'(v.wd));
    chk("truncate", idx, 32'(truncate), 32'(v.tr));
    chk("pktCount0", idx, 32'(pktCount0), 32'(v.c0));
    chk("pktCount1", idx, 32'(pktCount1), 32'(v.c1));
  endtask

  // One cycle: drive just after the rising edge, sample on the falling edge.
  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_outputs(v, idx);
    $display("vec %0d: grant=%b wv=%b wl=%b wd=%h trunc=%b cnt0=%0d cnt1=%0d",
             idx, grant, writeDataValid, writeDataLast, writeData, truncate, pktCount0, pktCount1);
  endtask

  initial begin
    vec_t v;
    int   n;

    reset = 1'b0;
    in0Data = '0; in0Valid = 1'b0; in0Last = 1'b0;
    in1Data = '0; in1Valid = 1'b0; in1Last = 1'b0;
    writeDataReady = 1'b1;

    // Reset state, valids ignored while in reset
    add(0, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 0,0);
    add(0, 1,0,'hA0,  1,0,'h10,  1, 0, 0,0,0,0,0,     0, 0,0);
    // Single source 4-beat packet, then back to idle
    add(1, 1,0,'hA0,  0,0,0,     1, 0, 0,0,0,0,0,     0, 0,0);
    add(1, 1,0,'hA0,  0,0,0,     1, 1, 1,0,1,0,'hA0,  0, 0,0);
    add(1, 1,0,'hA1,  0,0,0,     1, 1, 1,0,1,0,'hA1,  0, 0,0);
    add(1, 1,0,'hA2,  0,0,0,     1, 1, 1,0,1,0,'hA2,  0, 0,0);
    add(1, 1,1,'hA3,  0,0,0,     1, 1, 1,0,1,1,'hA3,  0, 0,0);
    add(1, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 1,0);
    // Fresh reset, then both sources stream 3-beat packets
    add(0, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 0,0);
    add(1, 1,0,'h00,  1,0,'h10,  1, 0, 0,0,0,0,0,     0, 0,0);
    add(1, 1,0,'h00,  1,0,'h10,  1, 1, 1,0,1,0,'h00,  0, 0,0);
    add(1, 1,0,'h01,  1,0,'h10,  1, 1, 1,0,1,0,'h01,  0, 0,0);
    add(1, 1,1,'h02,  1,0,'h10,  1, 1, 1,0,1,1,'h02,  0, 0,0);
    add(1, 1,0,'h03,  1,0,'h10,  1, 2, 0,1,1,0,'h10,  0, 1,0);
    add(1, 1,0,'h03,  1,0,'h11,  1, 2, 0,1,1,0,'h11,  0, 1,0);
    add(1, 1,0,'h03,  1,1,'h12,  1, 2, 0,1,1,1,'h12,  0, 1,0);
    add(1, 1,0,'h03,  1,0,'h13,  1, 1, 1,0,1,0,'h03,  0, 1,1);
    add(1, 1,0,'h04,  1,0,'h13,  1, 1, 1,0,1,0,'h04,  0, 1,1);
    add(1, 1,1,'h05,  1,0,'h13,  1, 1, 1,0,1,1,'h05,  0, 1,1);
    add(1, 0,0,0,     1,0,'h13,  1, 2, 0,1,1,0,'h13,  0, 2,1);
    add(1, 0,0,0,     1,0,'h14,  1, 2, 0,1,1,0,'h14,  0, 2,1);
    add(1, 0,0,0,     1,1,'h15,  1, 2, 0,1,1,1,'h15,  0, 2,1);
    add(1, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 2,2);
    // Backpressure 1,0,0,1 during a source 1 packet
    add(1, 0,0,0,     1,0,'h20,  1, 0, 0,0,0,0,0,     0, 2,2);
    add(1, 0,0,0,     1,0,'h20,  1, 2, 0,1,1,0,'h20,  0, 2,2);
    add(1, 0,0,0,     1,0,'h21,  0, 2, 0,0,1,0,'h21,  0, 2,2);
    add(1, 0,0,0,     1,0,'h21,  0, 2, 0,0,1,0,'h21,  0, 2,2);
    add(1, 0,0,0,     1,0,'h21,  1, 2, 0,1,1,0,'h21,  0, 2,2);
    add(1, 0,0,0,     1,1,'h22,  1, 2, 0,1,1,1,'h22,  0, 2,2);
    add(1, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 2,3);
    // Fresh reset, then a 10-beat packet truncated at beat 8 (with one stall)
    add(0, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 0,0);
    add(1, 1,0,'h30,  0,0,0,     1, 0, 0,0,0,0,0,     0, 0,0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) add(1, 1,0,'h33, 0,0,0, 0, 1, 0,0,1,0,'h33, 0, 0,0);
      add(1, 1,0,'h30+k, 0,0,0, 1, 1, 1,0,1,(k == 7) ? 1 : 0,'h30+k, 0, 0,0);
    end
    add(1, 1,0,'h38,  0,0,0,     1, 1, 1,0,1,0,'h38,  1, 1,0);
    add(1, 1,1,'h39,  0,0,0,     1, 1, 1,0,1,1,'h39,  0, 1,0);
    add(1, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 2,0);
    // Source 1 sends five single-beat packets; counter wraps 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      add(1, 0,0,0, 1,1,'h40+k, 1, 0, 0,0,0,0,0,       0, 2,k % 4);
      add(1, 0,0,0, 1,1,'h40+k, 1, 2, 0,1,1,1,'h40+k,  0, 2,k % 4);
    end
    add(1, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 2,1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    n = vecs.size();

    // Reset in the middle of a 5-beat source 0 packet, taken between edges
    vecs.delete();
    add(1, 1,0,'h50,  0,0,0,     1, 0, 0,0,0,0,0,     0, 2,1);
    add(1, 1,0,'h50,  0,0,0,     1, 1, 1,0,1,0,'h50,  0, 2,1);
    add(1, 1,0,'h51,  0,0,0,     1, 1, 1,0,1,0,'h51,  0, 2,1);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], n + i);
    n = n + vecs.size();
    @(posedge clk);
    #1;
    in0Data = 8'h52;
    #2;
    reset = 1'b0;
    #1;
    add(0, 1,0,'h52,  0,0,0,     1, 0, 0,0,0,0,0,     0, 0,0);
    v = vecs[vecs.size() - 1];
    check_outputs(v, n);
    $display("vec %0d: async reset mid-packet grant=%b wv=%b cnt0=%0d", n, grant, writeDataValid, pktCount0);
    n++;

    // After release, a source 1 packet is granted normally
    vecs.delete();
    add(0, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 0,0);
    add(1, 0,0,0,     1,0,'h60,  1, 0, 0,0,0,0,0,     0, 0,0);
    add(1, 0,0,0,     1,0,'h60,  1, 2, 0,1,1,0,'h60,  0, 0,0);
    add(1, 0,0,0,     1,1,'h61,  1, 2, 0,1,1,1,'h61,  0, 0,0);
    add(1, 0,0,0,     0,0,0,     1, 0, 0,0,0,0,0,     0, 0,1);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], n + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
